// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Memory stage between execute and writeback. Handles byte, half,
//            word and dword loads with sign or zero extension, and byte-enabled
//            stores over a req/gnt/rvalid data-memory port. Misaligned
//            accesses and memory timeouts are flagged rather than issued or
//            left hanging.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_ld_op,
  input  logic                 is_str_op,
  input  logic [1:0]           mem_size,
  input  logic                 ld_unsigned,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [XLEN-1:0]      st_val,
  input  logic [4:0]           rd_num,
  output logic                 out_valid,
  output logic [4:0]           out_rd_num,
  output logic [XLEN-1:0]      out_val,
  output logic                 out_wr_en,
  output logic                 misalign_err,
  output logic                 timeout_err,
  output logic                 dmem_req,
  input  logic                 dmem_gnt,
  output logic [ADDR_W-1:0]    dmem_addr,
  output logic                 dmem_write_en,
  output logic [XLEN/8-1:0]    dmem_be,
  output logic [XLEN-1:0]      dmem_val_out,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_val_in
);

  localparam int NB    = XLEN / 8;
  localparam int OFS   = $clog2(NB);
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  a_addr;
  logic [1:0]         a_size;
  logic               a_uns, a_we;
  logic [XLEN-1:0]    a_st;
  logic [4:0]         a_rd;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [XLEN-1:0]    res_val, res_val_d;
  logic               res_wr, res_wr_d, res_mis, res_mis_d, res_to, res_to_d;

  logic               accept, is_mem, misal, timeout_hit, in_req, st_req;
  logic [OFS-1:0]     lane;
  logic [XLEN-1:0]    shifted, ld_ext, st_rep;
  logic [NB-1:0]      be_mask;

  assign accept      = in_valid && (state == IDLE);
  assign is_mem      = is_ld_op || is_str_op;
  assign lane        = a_addr[OFS-1:0];
  assign shifted     = dmem_val_in >> {lane, 3'b000};
  // The abort fires on the last allowed REQ/WAIT cycle so the request is
  // visible for exactly TIMEOUT_CYC cycles.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign in_req      = (state == REQ);
  assign st_req      = in_req && a_we;

  // Alignment check on the incoming op; dword is illegal on a 32-bit datapath.
  always_comb begin
    misal = 1'b0;
    case (mem_size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = mem_addr[0];
      2'b10:   misal = |mem_addr[1:0];
      default: misal = (XLEN == 32) ? 1'b1 : |mem_addr[2:0];
    endcase
  end

  // Select the addressed lane and extend it to the full data width.
  always_comb begin
    ld_ext = shifted;
    case (a_size)
      2'b00:   ld_ext = a_uns ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'b01:   ld_ext = a_uns ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'b10:   ld_ext = a_uns ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ld_ext = shifted;
    endcase
  end

  // Store byte-enable mask and data replicated across every size-wide slot.
  always_comb begin
    be_mask = '1;
    st_rep  = a_st;
    case (a_size)
      2'b00: begin
        be_mask = NB'(1);
        st_rep  = {NB{a_st[7:0]}};
      end
      2'b01: begin
        be_mask = NB'(3);
        st_rep  = {(NB/2){a_st[15:0]}};
      end
      2'b10: begin
        be_mask = NB'(15);
        st_rep  = {(NB/4){a_st[31:0]}};
      end
      default: begin
        be_mask = '1;
        st_rep  = a_st;
      end
    endcase
    be_mask = be_mask << lane;
  end

  // Next-state, timeout counter and result-register logic.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    res_val_d = res_val;
    res_wr_d  = res_wr;
    res_mis_d = res_mis;
    res_to_d  = res_to;
    case (state)
      IDLE: begin
        if (in_valid) begin
          cnt_d     = '0;
          res_val_d = '0;
          res_wr_d  = 1'b0;
          res_mis_d = 1'b0;
          res_to_d  = 1'b0;
          if (!is_mem) begin
            state_d   = DONE;
            res_val_d = XLEN'(mem_addr);
          end else if (misal) begin
            state_d   = DONE;
            res_mis_d = 1'b1;
          end else begin
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt + 1'b1;
        if (dmem_gnt) begin
          if (a_we) begin
            state_d = DONE;
          end else if (dmem_rvalid) begin
            state_d   = DONE;
            res_val_d = ld_ext;
            res_wr_d  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else if (timeout_hit) begin
          state_d  = DONE;
          res_to_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt + 1'b1;
        if (dmem_rvalid) begin
          state_d   = DONE;
          res_val_d = ld_ext;
          res_wr_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d  = DONE;
          res_to_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, captured op and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      res_val <= '0;
      res_wr  <= 1'b0;
      res_mis <= 1'b0;
      res_to  <= 1'b0;
      a_addr  <= '0;
      a_size  <= 2'b00;
      a_uns   <= 1'b0;
      a_we    <= 1'b0;
      a_st    <= '0;
      a_rd    <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      res_val <= res_val_d;
      res_wr  <= res_wr_d;
      res_mis <= res_mis_d;
      res_to  <= res_to_d;
      if (accept) begin
        a_addr <= mem_addr;
        a_size <= mem_size;
        a_uns  <= ld_unsigned;
        a_we   <= !is_ld_op && is_str_op;
        a_st   <= st_val;
        a_rd   <= rd_num;
      end
    end
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign out_rd_num    = out_valid ? a_rd    : '0;
  assign out_val       = out_valid ? res_val : '0;
  assign out_wr_en     = out_valid && res_wr;
  assign misalign_err  = out_valid && res_mis;
  assign timeout_err   = out_valid && res_to;

  assign dmem_req      = in_req;
  assign dmem_addr     = in_req ? {a_addr[ADDR_W-1:OFS], {OFS{1'b0}}} : '0;
  assign dmem_write_en = st_req;
  assign dmem_be       = st_req ? be_mask : '0;
  assign dmem_val_out  = st_req ? st_rep  : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit (XLEN=32,
//            TIMEOUT_CYC=8) with a scoreboard of expected writeback results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, is_ld_op, is_str_op, ld_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, st_val;
  logic [4:0]  rd_num, out_rd_num;
  logic        out_valid, out_wr_en, misalign_err, timeout_err;
  logic [31:0] out_val;
  logic        dmem_req, dmem_gnt, dmem_write_en, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_val_out, dmem_val_in;
  logic [3:0]  dmem_be;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
    logic        wr;
    logic        mis;
    logic        to;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_ld_op(is_ld_op), .is_str_op(is_str_op),
    .mem_size(mem_size), .ld_unsigned(ld_unsigned),
    .mem_addr(mem_addr), .st_val(st_val), .rd_num(rd_num),
    .out_valid(out_valid), .out_rd_num(out_rd_num), .out_val(out_val),
    .out_wr_en(out_wr_en), .misalign_err(misalign_err), .timeout_err(timeout_err),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_addr(dmem_addr),
    .dmem_write_en(dmem_write_en), .dmem_be(dmem_be), .dmem_val_out(dmem_val_out),
    .dmem_rvalid(dmem_rvalid), .dmem_val_in(dmem_val_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] val,
                      input logic wr, input logic mis, input logic to);
    exp_t e;
    e.rd = rd; e.val = val; e.wr = wr; e.mis = mis; e.to = to;
    sb.push_back(e);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one op; waits (bounded) for in_ready, returns 1ns after the accept edge.
  task automatic accept(input logic ld, input logic st, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] sv, input logic [4:0] rd);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      sync();
      n++;
    end
    if (n == 20) chk("accept_ready_timeout", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; is_ld_op = ld; is_str_op = st; mem_size = size;
    ld_unsigned = uns; mem_addr = addr; st_val = sv; rd_num = rd;
    sync();
    in_valid = 1'b0; is_ld_op = 1'b0; is_str_op = 1'b0;
  endtask

  // Scoreboard: every result pulse is matched against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected: observed out_valid rd=%0d val=%0h expected none",
               out_rd_num, out_val);
      end else begin
        e = sb.pop_front();
        checks++;
        assert ({out_rd_num, out_val, out_wr_en, misalign_err, timeout_err} === e) else begin
          errors++;
          $error("FAIL sb_result: observed rd=%0d val=%0h wr=%0b mis=%0b to=%0b expected rd=%0d val=%0h wr=%0b mis=%0b to=%0b",
                 out_rd_num, out_val, out_wr_en, misalign_err, timeout_err,
                 e.rd, e.val, e.wr, e.mis, e.to);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1; in_valid = 1'b0; is_ld_op = 1'b0; is_str_op = 1'b0;
    mem_size = 2'b00; ld_unsigned = 1'b0; mem_addr = '0; st_val = '0; rd_num = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_val_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
    sync();
    rst = 1'b0;

    // T1 signed byte load at 0x1003, grant then rvalid one cycle later
    push(5'd3, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
    accept(1'b1, 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 5'd3);
    dmem_gnt = 1'b1;
    @(negedge clk);
    chk("t1_req", {63'd0, dmem_req}, 64'd1);
    chk("t1_addr", {32'd0, dmem_addr}, 64'h1000);
    chk("t1_be", {60'd0, dmem_be}, 64'h0);
    chk("t1_we", {63'd0, dmem_write_en}, 64'd0);
    sync();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_val_in = 32'h8011_2233;
    @(negedge clk);
    chk("t1_wait_req", {63'd0, dmem_req}, 64'd0);
    sync();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
    sync();

    // T1 unsigned variant
    push(5'd4, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
    accept(1'b1, 1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 5'd4);
    dmem_gnt = 1'b1;
    sync();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_val_in = 32'h8011_2233;
    sync();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("t1u_out_valid", {63'd0, out_valid}, 64'd1);
    sync();

    // T2 half store at 0x2002, immediate grant
    push(5'd7, 32'h0, 1'b0, 1'b0, 1'b0);
    accept(1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234_ABCD, 5'd7);
    dmem_gnt = 1'b1;
    @(negedge clk);
    chk("t2_early_valid", {63'd0, out_valid}, 64'd0);
    chk("t2_addr", {32'd0, dmem_addr}, 64'h2000);
    chk("t2_be", {60'd0, dmem_be}, 64'hC);
    chk("t2_data", {32'd0, dmem_val_out}, 64'hABCD_ABCD);
    chk("t2_we", {63'd0, dmem_write_en}, 64'd1);
    sync();
    dmem_gnt = 1'b0;
    @(negedge clk);
    chk("t2_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t2_ready_low", {63'd0, in_ready}, 64'd0);
    sync();

    // Byte store at 0x5
    push(5'd8, 32'h0, 1'b0, 1'b0, 1'b0);
    accept(1'b0, 1'b1, 2'b00, 1'b0, 32'h0005, 32'hFFFF_FF5A, 5'd8);
    dmem_gnt = 1'b1;
    @(negedge clk);
    chk("bst_addr", {32'd0, dmem_addr}, 64'h4);
    chk("bst_be", {60'd0, dmem_be}, 64'h2);
    chk("bst_data", {32'd0, dmem_val_out}, 64'h5A5A_5A5A);
    sync();
    dmem_gnt = 1'b0;
    sync();

    // T3 misaligned word load at 0x1001
    push(5'd9, 32'h0, 1'b0, 1'b1, 1'b0);
    accept(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001, 32'h0, 5'd9);
    @(negedge clk);
    chk("t3_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t3_no_req", {63'd0, dmem_req}, 64'd0);
    sync();

    // Non-memory op passes the address through
    push(5'd2, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    accept(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 5'd2);
    @(negedge clk);
    chk("nm_out_valid", {63'd0, out_valid}, 64'd1);
    sync();

    // T4 timeout: word load, grant held low
    push(5'd11, 32'h0, 1'b0, 1'b0, 1'b1);
    accept(1'b1, 1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 5'd11);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t4_req_%0d", i), {62'd0, dmem_req, out_valid}, 64'b10);
    end
    @(negedge clk);
    chk("t4_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t4_req_dropped", {63'd0, dmem_req}, 64'd0);
    @(negedge clk);
    chk("t4_ready_back", {63'd0, in_ready}, 64'd1);
    sync();

    // T5 reset during WAIT, then a stray rvalid
    accept(1'b1, 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, 5'd6);
    dmem_gnt = 1'b1;
    sync();
    dmem_gnt = 1'b0;
    @(negedge clk);
    chk("t5_in_wait", {62'd0, in_ready, dmem_req}, 64'b00);
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("t5_rst_outs", {out_valid, out_rd_num, out_val, out_wr_en, misalign_err, timeout_err},
        64'd0);
    chk("t5_rst_dmem", {dmem_req, dmem_write_en, dmem_be, dmem_addr}, 64'd0);
    sync();
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_val_in = 32'h5555_5555;
    @(negedge clk);
    chk("t5_stray_valid", {62'd0, out_valid, in_ready}, 64'b01);
    sync();
    dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
    @(negedge clk);
    chk("t5_stray_after", {63'd0, out_valid}, 64'd0);
    sync();

    // T6 zero-latency word load at 0x40
    push(5'd1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    accept(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5'd1);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_val_in = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t6_addr", {32'd0, dmem_addr}, 64'h40);
    chk("t6_early_valid", {63'd0, out_valid}, 64'd0);
    sync();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", {63'd0, out_valid}, 64'd1);
    sync();

    // Signed half load from upper lane, zero-latency memory
    push(5'd12, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0);
    accept(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd12);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_val_in = 32'h8001_7FFF;
    sync();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("hl_out_valid", {63'd0, out_valid}, 64'd1);
    sync();
    sync();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
